// File: rtl/clk_rate_ctrl.sv
// Multi-level divided clock for slow-running the CPU, stepped up/down by two debounced buttons.
// Optional single-step mode (run / btn_step ports) is built when CLK_RATE_CTRL_STEP_EN is defined.
module clk_rate_ctrl #(
    parameter int NUM_LEVELS  = 4,
    parameter int DIV_BASE    = 50_000_000,
    parameter int CNT_W       = 32,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int START_LEVEL = 0,
    localparam int LVL_W      = $clog2(NUM_LEVELS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_faster,
    input  logic             btn_slower,
`ifdef CLK_RATE_CTRL_STEP_EN
    input  logic             run,
    input  logic             btn_step,
`endif
    output logic             clk_N,
    output logic             tick,
    output logic [LVL_W-1:0] level
);

`ifdef CLK_RATE_CTRL_STEP_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    localparam int               DEB_W     = $clog2(DEB_CYCLES) + 1;
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_TOP   = LVL_W'(NUM_LEVELS - 1);
    localparam logic [LVL_W-1:0] LVL_START = LVL_W'(START_LEVEL);

    logic [NB-1:0]    raw;
    logic [NB-1:0]    sync_p0;
    logic [NB-1:0]    sync_p1;
    logic [NB-1:0]    deb_p2;
    logic [NB-1:0]    deb_p3;
    logic [NB-1:0]    rise;
    logic [DEB_W-1:0] deb_cnt [NB];

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] half_m1;
    logic             wrap;
    logic             clk_nx;
    logic             tick_nx;
    logic [LVL_W-1:0] next_level;
    logic             level_chg;

    // Half-period minus one for a level; deep levels clamp to a half-period of one cycle.
    function automatic logic [CNT_W-1:0] half_m1_of(input logic [LVL_W-1:0] lvl);
        logic [CNT_W-1:0] h;
        h = CNT_W'(DIV_BASE) >> lvl;
        if (h == '0) h = CNT_W'(1);
        return h - CNT_W'(1);
    endfunction

`ifdef CLK_RATE_CTRL_STEP_EN
    logic run_d;
    assign raw = {btn_step, btn_slower, btn_faster};
`else
    assign raw = {btn_slower, btn_faster};
`endif

    // p0/p1: two-flop synchroniser; p2: debounced state; p3: delayed copy for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            deb_p2  <= '0;
            deb_p3  <= '0;
            for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            deb_p3  <= deb_p2;
            for (int i = 0; i < NB; i++) begin
                if (sync_p1[i] != deb_p2[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb_p2[i]  <= sync_p1[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign rise = deb_p2 & ~deb_p3;

    always_comb begin
        next_level = level;
        if (rise[0] && !rise[1]) begin
            if (level != LVL_TOP) next_level = level + LVL_W'(1);
        end else if (rise[1] && !rise[0]) begin
            if (level != '0) next_level = level - LVL_W'(1);
        end
        level_chg = (next_level != level);
    end

    always_comb begin
        half_m1 = half_m1_of(level);
        wrap    = (cnt == half_m1);
        cnt_nx  = cnt + CNT_W'(1);
        clk_nx  = clk_N;
        tick_nx = 1'b0;
`ifdef CLK_RATE_CTRL_STEP_EN
        if (!run) begin
            cnt_nx = cnt;
            if (run_d) begin
                clk_nx = 1'b0;
            end else if (clk_N) begin
                if (wrap) begin
                    cnt_nx = '0;
                    clk_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end else if (rise[2]) begin
                cnt_nx  = '0;
                clk_nx  = 1'b1;
                tick_nx = 1'b1;
            end
            if (level_chg) cnt_nx = '0;
        end else if (!run_d) begin
            cnt_nx = '0;
            clk_nx = 1'b0;
        end else
`endif
        if (level_chg) begin
            cnt_nx = '0;
        end else if (wrap) begin
            cnt_nx  = '0;
            clk_nx  = ~clk_N;
            tick_nx = ~clk_N;
        end
    end

    // Output stage: divider state, tick and level all registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            clk_N <= 1'b0;
            tick  <= 1'b0;
            level <= LVL_START;
`ifdef CLK_RATE_CTRL_STEP_EN
            run_d <= 1'b1;
`endif
        end else begin
            cnt   <= cnt_nx;
            clk_N <= clk_nx;
            tick  <= tick_nx;
            level <= next_level;
`ifdef CLK_RATE_CTRL_STEP_EN
            run_d <= run;
`endif
        end
    end

endmodule
